// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Definitions shared by the 8B/10B transmit serializer and the receive-side
// comma detector / disparity checker.
//   SYM_W      : width of one encoded symbol {a,b,c,d,e,i,f,g,h,j}
//   K28_5_RDN  : K28.5 comma for use when running disparity is negative
//   K28_5_RDP  : K28.5 comma for use when running disparity is positive
//   ser_state_t: serializer state machine encoding
// ---------------------------------------------------------------------------
package enc_pkg;

   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
   localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ser_state_t;

   // Comma that keeps the line DC balanced for the given running disparity.
   function automatic logic [SYM_W-1:0] k28_5_for(input logic rd_pos);
      return rd_pos ? K28_5_RDP : K28_5_RDN;
   endfunction

endpackage

// File: rtl/sym_disp.sv
// ---------------------------------------------------------------------------
// sym_disp
// Classifies a 10-bit symbol by its ones count.
//   sym     in  SYM_W  symbol to classify
//   neutral out 1      exactly 5 ones
//   pos     out 1      exactly 6 ones (positive disparity)
//   neg     out 1      exactly 4 ones (negative disparity)
//   illegal out 1      any other ones count
// Purely combinational.
// ---------------------------------------------------------------------------
module sym_disp
   import enc_pkg::*;
(
   input  logic [SYM_W-1:0] sym,
   output logic             neutral,
   output logic             pos,
   output logic             neg,
   output logic             illegal
);

   logic [3:0] ones;

   always_comb begin
      ones = 4'd0;
      for (int i = 0; i < SYM_W; i++) begin
         ones = ones + {3'b000, sym[i]};
      end
   end

   assign neutral = (ones == 4'd5);
   assign pos     = (ones == 4'd6);
   assign neg     = (ones == 4'd4);
   assign illegal = ~(neutral | pos | neg);

endmodule

// File: rtl/enc_serializer.sv
// ---------------------------------------------------------------------------
// enc_serializer
// Parallel-to-serial output stage of the 8B/10B encoder. Symbols pass through
// a one-entry holding buffer into a 10-bit shifter and leave MSB (bit a)
// first, one bit per clock. When no symbol is buffered at a symbol boundary a
// K28.5 comma of the correct polarity is sent instead, so the line never
// idles mid-stream. Running disparity is tracked locally.
//
// Handshake: a symbol transfers on a rising edge where sym_valid & sym_ready.
// sym_ready is high when the buffer is empty or is being emptied by a load in
// the same cycle; an accepted symbol always sits in the buffer for at least
// one cycle before it can be loaded.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   sym_in     in   SYM_W encoded symbol, bit 9 (a) sent first
//   sym_valid  in   sym_in is valid
//   sym_ready  out  buffer can accept a symbol
//   tx_en      in   enable transmission
//   sdout      out  serial data (registered)
//   sym_start  out  sdout carries bit a of a symbol
//   comma_ins  out  with sym_start: symbol is an inserted K28.5
//   rd         out  running disparity (1 = RD+), updated on load
//   disp_err   out  sticky: an illegal symbol was loaded
// ---------------------------------------------------------------------------
module enc_serializer
   import enc_pkg::*;
#(
   parameter bit INIT_RD = 1'b0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [SYM_W-1:0] sym_in,
   input  logic             sym_valid,
   output logic             sym_ready,
   input  logic             tx_en,
   output logic             sdout,
   output logic             sym_start,
   output logic             comma_ins,
   output logic             rd,
   output logic             disp_err
);

   ser_state_t       state;
   logic [3:0]       cnt;
   logic [SYM_W-1:0] shreg;
   logic [SYM_W-1:0] buf_sym;
   logic             buf_full;

   logic             load;
   logic             accept;
   logic [SYM_W-1:0] load_sym;
   logic             d_neutral, d_pos, d_neg, d_illegal;

   // A load happens when leaving IDLE or at the last bit of a symbol, and
   // only while transmission is enabled.
   always_comb begin
      load = 1'b0;
      if (tx_en) begin
         if (state == IDLE)       load = 1'b1;
         else if (cnt == 4'd9)    load = 1'b1;
      end
   end

   assign load_sym  = buf_full ? buf_sym : k28_5_for(rd);
   assign sym_ready = ~buf_full | load;
   assign accept    = sym_valid & sym_ready;

   sym_disp u_sym_disp (
      .sym     (load_sym),
      .neutral (d_neutral),
      .pos     (d_pos),
      .neg     (d_neg),
      .illegal (d_illegal)
   );

   // Holding buffer. A same-cycle accept refills it as the old content is
   // moved to the shifter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_full <= 1'b0;
         buf_sym  <= '0;
      end else if (accept) begin
         buf_full <= 1'b1;
         buf_sym  <= sym_in;
      end else if (load) begin
         buf_full <= 1'b0;
      end
   end

   // Running disparity. The symbol is always sent as-is; a wrong-polarity or
   // unbalanced symbol only raises the sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd       <= INIT_RD;
         disp_err <= 1'b0;
      end else if (load) begin
         if (d_illegal | (d_pos & rd) | (d_neg & ~rd)) disp_err <= 1'b1;
         if (!(d_neutral | d_illegal))                 rd       <= d_pos;
      end
   end

   // Serializer FSM with registered line outputs. On a load, bit a goes
   // straight to sdout and the remaining nine bits wait in the shifter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         shreg     <= '0;
         sdout     <= 1'b0;
         sym_start <= 1'b0;
         comma_ins <= 1'b0;
      end else if (load) begin
         state     <= RUN;
         cnt       <= 4'd0;
         sdout     <= load_sym[SYM_W-1];
         shreg     <= {load_sym[SYM_W-2:0], 1'b0};
         sym_start <= 1'b1;
         comma_ins <= ~buf_full;
      end else begin
         case (state)
            RUN: begin
               sym_start <= 1'b0;
               comma_ins <= 1'b0;
               if (cnt == 4'd9) begin
                  // Symbol finished and tx_en is low: park the line.
                  state <= IDLE;
                  cnt   <= 4'd0;
                  sdout <= 1'b0;
               end else begin
                  cnt   <= cnt + 4'd1;
                  sdout <= shreg[SYM_W-1];
                  shreg <= {shreg[SYM_W-2:0], 1'b0};
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= 4'd0;
               sdout     <= 1'b0;
               sym_start <= 1'b0;
               comma_ins <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enc_serializer.sv
// ---------------------------------------------------------------------------
// tb_enc_serializer
// Directed bench for enc_serializer. Expected symbols are queued as
// {rd_after_load, comma_flag, symbol} when stimulus is applied and compared
// as each symbol appears on sdout.
// ---------------------------------------------------------------------------
module tb_enc_serializer;
   import enc_pkg::*;

   localparam logic [9:0] D21_5 = 10'b1010101010;
   localparam logic [9:0] S_POS = 10'b1100011011;  // 6 ones
   localparam logic [9:0] S_NEG = 10'b0100100101;  // 4 ones
   localparam logic [9:0] S_NEU = 10'b0101010101;  // 5 ones
   localparam logic [9:0] S_BAD = 10'b1111111000;  // 7 ones
   localparam logic [9:0] C_RDN = 10'b0011111010;
   localparam logic [9:0] C_RDP = 10'b1100000101;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] sym_in;
   logic       sym_valid;
   logic       sym_ready;
   logic       tx_en;
   logic       sdout;
   logic       sym_start;
   logic       comma_ins;
   logic       rd;
   logic       disp_err;

   int total = 0;
   int bad   = 0;
   logic [11:0] exp_q[$];

   always #5 clk = ~clk;

   enc_serializer #(.INIT_RD(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .sym_in    (sym_in),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .tx_en     (tx_en),
      .sdout     (sdout),
      .sym_start (sym_start),
      .comma_ins (comma_ins),
      .rd        (rd),
      .disp_err  (disp_err)
   );

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic r, input logic c, input logic [9:0] s);
      exp_q.push_back({r, c, s});
   endtask

   // Waits (bounded) for the next negedge where sym_start is high.
   task automatic wait_start(input string tag, output logic found, output int gap);
      found = 1'b0;
      gap   = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (sym_start === 1'b1) begin
            found = 1'b1;
            gap   = i;
            break;
         end
      end
      chk({tag, " start_seen"}, 12'(found), 12'd1);
   endtask

   // Collects one symbol from sdout and checks it against the queue head.
   // Every symbol here is expected to start on the very next cycle.
   task automatic recv_sym(input string tag);
      logic        found;
      int          gap;
      logic [11:0] e;
      logic [9:0]  got;
      logic        extra;
      wait_start(tag, found, gap);
      if (found) begin
         chk({tag, " gap"}, 12'(gap), 12'd1);
         chk({tag, " pending"}, 12'(exp_q.size() > 0), 12'd1);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
         got[9] = sdout;
         chk({tag, " comma"}, 12'(comma_ins), 12'(e[10]));
         chk({tag, " rd"}, 12'(rd), 12'(e[11]));
         extra = 1'b0;
         for (int k = 8; k >= 0; k--) begin
            @(negedge clk);
            got[k] = sdout;
            if (sym_start !== 1'b0) extra = 1'b1;
         end
         chk({tag, " bits"}, 12'(got), 12'(e[9:0]));
         chk({tag, " no_restart"}, 12'(extra), 12'd0);
      end
   endtask

   // Presents one symbol; returns at the negedge after the accepting edge.
   task automatic send(input string tag, input logic [9:0] s);
      logic done;
      done      = 1'b0;
      sym_valid = 1'b1;
      sym_in    = s;
      for (int i = 0; i < 40 && !done; i++) begin
         #1;
         if (sym_ready === 1'b1) done = 1'b1;
         @(negedge clk);
      end
      chk({tag, " accepted"}, 12'(done), 12'd1);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      tx_en     = 1'b0;
      sym_valid = 1'b0;
      #1;
      chk("reset outputs", {6'b0, sdout, sym_start, comma_ins, disp_err, rd, sym_ready},
          12'b000000_000001);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic found;
      int   gap;

      rst       = 1'b1;
      tx_en     = 1'b0;
      sym_valid = 1'b0;
      sym_in    = '0;
      #1;
      chk("async reset outputs", {6'b0, sdout, sym_start, comma_ins, disp_err, rd, sym_ready},
          12'b000000_000001);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle line with tx_en: alternating commas.
      @(negedge clk);
      chk("idle sdout", {10'b0, sdout, sym_start}, 12'd0);
      tx_en = 1'b1;
      push(1'b1, 1'b1, C_RDN);
      push(1'b0, 1'b1, C_RDP);
      push(1'b1, 1'b1, C_RDN);
      push(1'b0, 1'b1, C_RDP);
      recv_sym("comma0");
      recv_sym("comma1");
      recv_sym("comma2");
      recv_sym("comma3");

      // D21.5 at RD-, buffered while IDLE, then sent.
      @(negedge clk);
      do_reset();
      sym_valid = 1'b1;
      sym_in    = D21_5;
      @(negedge clk);
      sym_valid = 1'b0;
      #1;
      chk("buf full ready", 12'(sym_ready), 12'd0);
      tx_en = 1'b1;
      push(1'b0, 1'b0, D21_5);
      push(1'b1, 1'b1, C_RDN);
      recv_sym("d21_5");
      recv_sym("after_d21_5");

      // Four back-to-back symbols with sym_valid held high.
      push(1'b0, 1'b1, C_RDP);
      push(1'b0, 1'b0, D21_5);
      push(1'b1, 1'b0, S_POS);
      push(1'b0, 1'b0, S_NEG);
      push(1'b0, 1'b0, S_NEU);
      push(1'b1, 1'b1, C_RDN);
      fork
         begin
            send("burst0", D21_5);
            send("burst1", S_POS);
            send("burst2", S_NEG);
            send("burst3", S_NEU);
            sym_valid = 1'b0;
         end
         begin
            recv_sym("pre_burst");
            recv_sym("burst_s0");
            recv_sym("burst_s1");
            recv_sym("burst_s2");
            recv_sym("burst_s3");
            recv_sym("post_burst");
         end
      join
      chk("burst disp_err", 12'(disp_err), 12'd0);

      // Illegal 7-ones symbol: sent verbatim, sticky error, rd unchanged.
      push(1'b0, 1'b1, C_RDP);
      push(1'b0, 1'b0, S_BAD);
      push(1'b1, 1'b1, C_RDN);
      fork
         begin
            send("bad", S_BAD);
            sym_valid = 1'b0;
         end
         begin
            recv_sym("pre_bad");
            chk("disp_err before", 12'(disp_err), 12'd0);
            recv_sym("bad_sym");
            chk("disp_err set", 12'(disp_err), 12'd1);
            recv_sym("post_bad");
            chk("disp_err sticky", 12'(disp_err), 12'd1);
         end
      join

      // tx_en dropped at cnt=4 with a symbol buffered.
      push(1'b0, 1'b1, C_RDP);
      fork
         begin
            send("held", S_POS);
            sym_valid = 1'b0;
         end
         recv_sym("before_drop");
         begin
            wait_start("drop", found, gap);
            repeat (4) @(negedge clk);
            tx_en = 1'b0;
         end
      join
      #1;
      chk("held ready", 12'(sym_ready), 12'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle line", {10'b0, sdout, sym_start}, 12'd0);
      end
      tx_en = 1'b1;
      push(1'b1, 1'b0, S_POS);
      push(1'b0, 1'b1, C_RDP);
      recv_sym("held_sym");
      recv_sym("after_held");

      // Reset at cnt=6 with a symbol buffered.
      fork
         begin
            send("lost", S_NEU);
            sym_valid = 1'b0;
         end
         begin
            wait_start("pre_rst", found, gap);
            repeat (6) @(negedge clk);
            chk("pre_rst rd", 12'(rd), 12'd1);
            #2;
            rst = 1'b1;
            #1;
            chk("mid rst outputs", {6'b0, sdout, sym_start, comma_ins, disp_err, rd, sym_ready},
                12'b000000_000001);
         end
      join
      tx_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst idle", {10'b0, sdout, sym_start}, 12'd0);
      end
      tx_en = 1'b1;
      push(1'b1, 1'b1, C_RDN);
      recv_sym("post_rst");
      tx_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("final idle", {10'b0, sdout, sym_start}, 12'd0);
      chk("queue drained", 12'(exp_q.size()), 12'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
